// File: rtl/atm_account_server.sv
// -----------------------------------------------------------------------------
// atm_account_server
//
// Back-end responder for the ATM front-end. Holds one account: PIN, balance,
// session authentication flag and the consecutive wrong-PIN counter. Each
// request is accepted on a valid/ready pair, processed for LATENCY cycles, and
// answered on a second valid/ready pair.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The side raising valid keeps valid and its
// payload stable until that edge. Ready may change freely.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   req_valid/req_ready   request channel (front-end -> this block)
//   req_op                00 deposit, 01 balance, 10 withdraw, 11 verify PIN
//   req_password          PIN checked by op 11
//   req_amount            deposit/withdraw amount
//   session_end           1-cycle pulse, drops authentication
//   rsp_valid/rsp_ready   response channel (this block -> front-end)
//   rsp_ok                request succeeded
//   rsp_incorrectpswd     wrong PIN, not authenticated, or account locked
//   rsp_nobalance         withdraw larger than balance
//   rsp_balance           balance after the operation
//   locked                sticky lockout after MAX_TRIES wrong PINs
//   state_dbg             current FSM state, for observation only
// -----------------------------------------------------------------------------
module atm_account_server #(
  parameter logic [3:0]  PIN          = 4'b0110,
  parameter int unsigned BAL_W        = 10,
  parameter int unsigned INIT_BALANCE = 100,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned LATENCY      = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [3:0]       req_password,
  input  logic [6:0]       req_amount,
  input  logic             session_end,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic             rsp_incorrectpswd,
  output logic             rsp_nobalance,
  output logic [BAL_W-1:0] rsp_balance,
  output logic             locked,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PROCESS = 2'd1,
    S_RESPOND = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam logic [1:0] OP_DEPOSIT  = 2'b00;
  localparam logic [1:0] OP_BALANCE  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;
  localparam logic [1:0] OP_VERIFY   = 2'b11;

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [BAL_W-1:0] BAL_INIT = BAL_W'(INIT_BALANCE);
  localparam logic [2:0]       TRIES_MAX = 3'(MAX_TRIES);

  state_t state, state_nx;

  // Request fields captured at accept
  logic [1:0]       op_q;
  logic [3:0]       pwd_q;
  logic [6:0]       amt_q;
  logic             auth_q;

  // Account state
  logic             auth;
  logic [2:0]       tries;
  logic             locked_q;
  logic [BAL_W-1:0] balance;
  logic [CNT_W-1:0] cnt;

  // Registered response flags
  logic             ok_q;
  logic             inc_q;
  logic             nob_q;

  // Commit results
  logic             last_cycle;
  logic             res_ok;
  logic             res_inc;
  logic             res_nob;
  logic [BAL_W-1:0] res_bal;
  logic             res_auth_set;
  logic             res_auth_clr;
  logic [2:0]       res_tries;
  logic             res_lock;
  logic [BAL_W:0]   dep_sum;
  logic [2:0]       tries_inc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = S_PROCESS;
      end
      S_PROCESS: begin
        if (last_cycle) state_nx = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = locked_q ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = S_RESPOND;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign last_cycle = (state == S_PROCESS) && (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Operation evaluation, using the auth value latched at accept
  // ---------------------------------------------------------------------------
  assign dep_sum   = {1'b0, balance} + (BAL_W + 1)'(amt_q);
  assign tries_inc = tries + 3'd1;

  always_comb begin
    res_ok       = 1'b0;
    res_inc      = 1'b0;
    res_nob      = 1'b0;
    res_bal      = balance;
    res_auth_set = 1'b0;
    res_auth_clr = 1'b0;
    res_tries    = tries;
    res_lock     = 1'b0;
    if (op_q == OP_VERIFY) begin
      if (pwd_q == PIN) begin
        res_ok       = 1'b1;
        res_auth_set = 1'b1;
        res_tries    = 3'd0;
      end else begin
        res_inc      = 1'b1;
        res_auth_clr = 1'b1;
        res_tries    = tries_inc;
        res_lock     = (tries_inc >= TRIES_MAX);
      end
    end else if (!auth_q) begin
      res_inc = 1'b1;
    end else begin
      case (op_q)
        OP_DEPOSIT: begin
          // Overflow beyond BAL_W bits rejects the deposit with no flag set
          if (!dep_sum[BAL_W]) begin
            res_ok  = 1'b1;
            res_bal = dep_sum[BAL_W-1:0];
          end
        end
        OP_BALANCE: begin
          res_ok = 1'b1;
        end
        OP_WITHDRAW: begin
          if (BAL_W'(amt_q) > balance) begin
            res_nob = 1'b1;
          end else begin
            res_ok  = 1'b1;
            res_bal = balance - BAL_W'(amt_q);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= 2'b00;
      pwd_q    <= 4'd0;
      amt_q    <= 7'd0;
      auth_q   <= 1'b0;
      auth     <= 1'b0;
      tries    <= 3'd0;
      locked_q <= 1'b0;
      balance  <= BAL_INIT;
      cnt      <= '0;
      ok_q     <= 1'b0;
      inc_q    <= 1'b0;
      nob_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        op_q   <= req_op;
        pwd_q  <= req_password;
        amt_q  <= req_amount;
        auth_q <= auth;
        cnt    <= '0;
      end

      if (state == S_PROCESS && !last_cycle) begin
        cnt <= cnt + 1'b1;
      end

      if (last_cycle) begin
        balance <= res_bal;
        tries   <= res_tries;
        ok_q    <= res_ok;
        inc_q   <= res_inc;
        nob_q   <= res_nob;
        if (res_lock) locked_q <= 1'b1;
      end

      // Locked account: every request is refused, nothing else changes
      if (state == S_LOCKED && req_valid) begin
        ok_q  <= 1'b0;
        inc_q <= 1'b1;
        nob_q <= 1'b0;
      end

      // session_end has priority over a verify-success commit
      if (session_end) begin
        auth <= 1'b0;
      end else if (last_cycle && res_auth_set) begin
        auth <= 1'b1;
      end else if (last_cycle && res_auth_clr) begin
        auth <= 1'b0;
      end
    end
  end

  assign rsp_ok            = ok_q;
  assign rsp_incorrectpswd = inc_q;
  assign rsp_nobalance     = nob_q;
  assign rsp_balance       = balance;
  assign locked            = locked_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_atm_account_server.sv
// -----------------------------------------------------------------------------
// tb_atm_account_server
//
// Directed scenarios followed by a randomized phase. Expected responses come
// from a small account model (balance/auth/tries/locked as plain integers).
// -----------------------------------------------------------------------------
module tb_atm_account_server;

  localparam logic [3:0] PIN     = 4'b0110;
  localparam int         BAL_W   = 10;
  localparam int         INIT_BAL = 100;
  localparam int         MAX_TRIES = 3;
  localparam int         LATENCY = 2;
  localparam int         BAL_MAX = (1 << BAL_W) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [3:0]       req_password = 4'd0;
  logic [6:0]       req_amount = 7'd0;
  logic             session_end = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_ok;
  logic             rsp_incorrectpswd;
  logic             rsp_nobalance;
  logic [BAL_W-1:0] rsp_balance;
  logic             locked;
  logic [1:0]       state_dbg;

  always #5 clock = ~clock;

  atm_account_server #(
    .PIN(PIN), .BAL_W(BAL_W), .INIT_BALANCE(INIT_BAL),
    .MAX_TRIES(MAX_TRIES), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_password(req_password), .req_amount(req_amount),
    .session_end(session_end),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ok(rsp_ok), .rsp_incorrectpswd(rsp_incorrectpswd),
    .rsp_nobalance(rsp_nobalance), .rsp_balance(rsp_balance),
    .locked(locked), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and reference model
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  int m_bal;
  int m_auth;
  int m_tries;
  int m_locked;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bal    = INIT_BAL;
    m_auth   = 0;
    m_tries  = 0;
    m_locked = 0;
  endtask

  // Account rules; pushes ok, incorrectpswd, nobalance, balance to exp_q
  task automatic model_step(input int op, input int pwd, input int amt);
    int ok, inc, nob;
    ok = 0; inc = 0; nob = 0;
    if (m_locked != 0) begin
      inc = 1;
    end else if (op == 3) begin
      if (pwd == int'(PIN)) begin
        ok = 1; m_auth = 1; m_tries = 0;
      end else begin
        inc = 1; m_auth = 0; m_tries = m_tries + 1;
        if (m_tries >= MAX_TRIES) m_locked = 1;
      end
    end else if (m_auth == 0) begin
      inc = 1;
    end else if (op == 0) begin
      if (m_bal + amt <= BAL_MAX) begin
        m_bal = m_bal + amt; ok = 1;
      end
    end else if (op == 1) begin
      ok = 1;
    end else begin
      if (amt > m_bal) nob = 1;
      else begin
        m_bal = m_bal - amt; ok = 1;
      end
    end
    exp_q.push_back(32'(ok));
    exp_q.push_back(32'(inc));
    exp_q.push_back(32'(nob));
    exp_q.push_back(32'(m_bal));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clock);
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    rsp_ready    = 1'b0;
    session_end  = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_flags", {29'd0, rsp_ok, rsp_incorrectpswd, rsp_nobalance}, 32'd0);
    check("rst_balance", 32'(rsp_balance), 32'(INIT_BAL));
    check("rst_locked", 32'(locked), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse_session_end();
    @(negedge clock);
    session_end = 1'b1;
    @(negedge clock);
    session_end = 1'b0;
    m_auth = 0;
  endtask

  // One full transaction: issue, measure latency, check response, hold, release.
  // se_at != 0 pulses session_end at that cycle count after issue.
  task automatic do_req(input logic [1:0] op, input logic [3:0] pwd, input logic [6:0] amt,
                        input int hold, input int se_at);
    int w, lat, exp_lat;
    logic [31:0] e_ok, e_inc, e_nob, e_bal;
    exp_lat = (m_locked != 0) ? 1 : LATENCY + 1;
    model_step(int'(op), int'(pwd), int'(amt));
    if (se_at != 0) m_auth = 0;
    e_ok  = exp_q.pop_front();
    e_inc = exp_q.pop_front();
    e_nob = exp_q.pop_front();
    e_bal = exp_q.pop_front();

    @(negedge clock);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("req_ready_before", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_password = pwd;
    req_amount   = amt;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        check("req_ready_busy", 32'(req_ready), 32'd0);
      end
      session_end = (lat == se_at);
    end while (!rsp_valid && lat < 50);
    session_end = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_ok", 32'(rsp_ok), e_ok);
    check("rsp_incorrectpswd", 32'(rsp_incorrectpswd), e_inc);
    check("rsp_nobalance", 32'(rsp_nobalance), e_nob);
    check("rsp_balance", 32'(rsp_balance), e_bal);
    check("locked", 32'(locked), 32'(m_locked));

    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_flags", {29'd0, rsp_ok, rsp_incorrectpswd, rsp_nobalance},
            {29'd0, e_ok[0], e_inc[0], e_nob[0]});
      check("hold_balance", 32'(rsp_balance), e_bal);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    do_reset();

    // Verify, balance, deposit/withdraw, overdraw
    do_req(2'b11, PIN, 7'd0, 0, 0);
    do_req(2'b01, 4'd0, 7'd0, 0, 0);
    do_req(2'b00, 4'd0, 7'd74, 0, 0);
    do_req(2'b10, 4'd0, 7'd51, 0, 0);
    do_req(2'b10, 4'd0, 7'd124, 0, 0);
    do_req(2'b10, 4'd0, 7'd123, 0, 0);        // equal amount: balance to 0
    do_req(2'b00, 4'd0, 7'd100, 5, 0);        // response held 5 cycles

    // Climb to 1000 then overflow deposit is rejected
    for (int i = 0; i < 7; i++) do_req(2'b00, 4'd0, 7'd127, 0, 0);
    do_req(2'b00, 4'd0, 7'd11, 0, 0);
    do_req(2'b00, 4'd0, 7'd127, 0, 0);
    do_req(2'b00, 4'd0, 7'd23, 0, 0);         // exactly to 1023

    // No authentication after reset
    do_reset();
    do_req(2'b10, 4'd0, 7'd10, 0, 0);
    do_req(2'b11, PIN, 7'd0, 0, 0);
    pulse_session_end();
    do_req(2'b00, 4'd0, 7'd5, 0, 0);

    // Latched auth survives session_end during PROCESS
    do_req(2'b11, PIN, 7'd0, 0, 0);
    do_req(2'b00, 4'd0, 7'd9, 0, 1);
    do_req(2'b01, 4'd0, 7'd0, 0, 0);

    // session_end on the verify-success commit cycle wins
    do_req(2'b11, PIN, 7'd0, 0, LATENCY);
    do_req(2'b00, 4'd0, 7'd9, 0, 0);

    // Lockout
    do_req(2'b11, 4'b0011, 7'd0, 0, 0);
    do_req(2'b11, 4'b0011, 7'd0, 0, 0);
    do_req(2'b11, 4'b0011, 7'd0, 0, 0);
    do_req(2'b11, PIN, 7'd0, 2, 0);
    do_req(2'b01, 4'd0, 7'd0, 0, 0);

    // Reset in the middle of a deposit
    do_reset();
    do_req(2'b11, PIN, 7'd0, 0, 0);
    @(negedge clock);
    req_valid  = 1'b1;
    req_op     = 2'b00;
    req_amount = 7'd50;
    @(negedge clock);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_flags", {29'd0, rsp_ok, rsp_incorrectpswd, rsp_nobalance}, 32'd0);
    check("midrst_balance", 32'(rsp_balance), 32'(INIT_BAL));
    repeat (3) @(negedge clock);
    check("midrst_hold_balance", 32'(rsp_balance), 32'(INIT_BAL));
    reset_n = 1'b1;
    model_reset();
    do_req(2'b01, 4'd0, 7'd0, 0, 0);          // auth dropped by reset

    // Randomized phase
    for (int t = 0; t < 150; t++) begin
      logic [1:0] r_op;
      logic [3:0] r_pwd;
      logic [6:0] r_amt;
      r_op  = 2'($urandom_range(0, 3));
      r_pwd = ($urandom_range(0, 3) != 0) ? PIN : 4'($urandom_range(0, 15));
      r_amt = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) pulse_session_end();
      if (m_locked != 0 && $urandom_range(0, 2) == 0) do_reset();
      do_req(r_op, r_pwd, r_amt, int'($urandom_range(0, 2)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
